if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface for the P5 five-stage pipelined MIPS core.
- Owns the F-stage PC register and drives the fetch address to the combinational instruction memory.
- Captures the returned instruction into the IF/ID pipeline register.
- Computes the next PC from sequential, branch, j/jal and jr requests issued by the D stage; honours pipeline stalls from the hazard unit.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset.
- IM_BASE, 32'h0000_3000, byte address of instruction-memory word 0.
- IM_DEPTH, 4096, instruction-memory size in 32-bit words.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  freeze F_PC, IF/ID register and fetch_cnt this cycle.
- npc_sel  input  2  00 sequential, 01 branch, 10 j/jal, 11 jr.
- branch_taken  input  1  branch condition result from D stage; only used when npc_sel=01.
- d_imm16  input  16  branch offset field of the instruction in D.
- d_index26  input  26  jump index field of the instruction in D.
- jr_target  input  32  forwarded rs value for jr.
- im_instr  input  32  instruction word returned by instruction memory for F_PC, same cycle.
- F_PC  output  32  fetch address to instruction memory.
- D_instr  output  32  IF/ID instruction.
- D_pc  output  32  IF/ID PC.
- D_pc8  output  32  D_pc+8, the jal link value.
- D_valid  output  1  IF/ID holds a fetched instruction.
- fetch_err  output  1  sticky: a fetch fell outside the instruction-memory range.
- fetch_cnt  output  32  number of instructions latched into IF/ID since reset.

Behaviour:
- Reset values:
  - F_PC=PC_RESET.
  - D_instr=0 (nop), D_pc=0, D_pc8=8.
  - D_valid=0, fetch_err=0, fetch_cnt=0.
- Priority each edge: reset > stall > normal update.
- On stall=1, all registers hold, including fetch_err. The D stage keeps npc_sel and operands stable while stalled, so no redirect is lost.
- Normal update, next PC (npc):
  - 00: F_PC+4.
  - 01 with branch_taken=1: D_pc+4+(sext(d_imm16)<<2).
  - 01 with branch_taken=0: F_PC+4.
  - 10: {D_pc_plus4[31:28], d_index26, 2'b00}, where D_pc_plus4=D_pc+4.
  - 11: jr_target.
- Arithmetic is 32-bit modulo 2^32; wrap at 32'hFFFF_FFFC to 0 is silent.
- Delay slot: the instruction after a branch/jump is always fetched and executed. The redirect takes effect on the fetch following the slot, with zero bubbles.
- IF/ID update on a non-stalled edge:
  - D_instr<=fetched word, D_pc<=F_PC, D_pc8<=F_PC+8.
  - D_valid<=1, fetch_cnt<=fetch_cnt+1.
  - fetch_cnt saturates at 32'hFFFF_FFFF.
- Range check:
  - In range means IM_BASE <= F_PC < IM_BASE+4*IM_DEPTH and F_PC[1:0]=00.
  - Out of range: fetched word is forced to 0 (nop) instead of im_instr, and fetch_err<=1. PC update proceeds normally.
  - fetch_err clears only on reset.
- F_PC is combinationally independent of all inputs (registered output). The IF/ID latency is one cycle.
- Reset asserted mid-operation overrides stall and redirect on the same edge.

Optional Feature:
- Macro IF_FLUSH_EN adds input port flush (1 bit) for a delay-slot-free or exception build.
- With IF_FLUSH_EN defined, flush=1 on a non-stalled edge:
  - loads the IF/ID register with D_instr=0, D_valid=0, D_pc=F_PC, D_pc8=F_PC+8;
  - leaves fetch_cnt unchanged;
  - still updates F_PC to npc.
- stall has priority over flush.
- Without IF_FLUSH_EN, the port does not exist and IF/ID always captures the fetched word.

Test Plan:
- Reset, then 3 free-running cycles with npc_sel=00 -> F_PC 3000, 3004, 3008, 300C; D_pc lags F_PC by one cycle; fetch_cnt=3; D_valid=1 after first edge.
- D_pc=3008, npc_sel=01, branch_taken=1, d_imm16=16'hFFFE -> slot at 300C fetched, then F_PC=3004; with branch_taken=0 -> F_PC=3010.
- D_pc=3000, npc_sel=10, d_index26=26'h0000C10 -> after slot 3004, F_PC=0000_3040; D_pc8 for jal = 3008.
- npc_sel=11, jr_target=32'h0000_3100 with stall=1 for 2 cycles -> F_PC, D_instr and fetch_cnt frozen; on release F_PC=3100.
- jr_target=32'h0000_0010 (below IM_BASE) -> next D_instr=0, fetch_err=1 and stays 1; a subsequent sequential fetch at 0014 is also a nop; reset clears fetch_err.
- IF_FLUSH_EN build: flush=1 with D_pc=3004 -> D_instr=0, D_valid=0, fetch_cnt unchanged, F_PC advances; flush=1 with stall=1 -> no change.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Fetch stage of the P5 MIPS pipeline: F-stage PC, IF/ID register, next-PC selection, fetch range check.
// Optional build macro IF_FLUSH_EN adds a flush input that squashes the word entering IF/ID.
module if_fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_DEPTH = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        branch_taken,
  input  logic [15:0] d_imm16,
  input  logic [25:0] d_index26,
  input  logic [31:0] jr_target,
  input  logic [31:0] im_instr,
`ifdef IF_FLUSH_EN
  input  logic        flush,
`endif
  output logic [31:0] F_PC,
  output logic [31:0] D_instr,
  output logic [31:0] D_pc,
  output logic [31:0] D_pc8,
  output logic        D_valid,
  output logic        fetch_err,
  output logic [31:0] fetch_cnt
);

  localparam logic [1:0] SEL_SEQ    = 2'b00;
  localparam logic [1:0] SEL_BRANCH = 2'b01;
  localparam logic [1:0] SEL_JUMP   = 2'b10;
  localparam logic [1:0] SEL_JR     = 2'b11;

  // 33-bit limit so a memory ending exactly at 2^32 does not wrap the compare
  localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + (33'(IM_DEPTH) << 2);

  logic [31:0] r_f_pc;
  logic [31:0] r_d_instr;
  logic [31:0] r_d_pc;
  logic [31:0] r_d_pc8;
  logic        r_d_valid;
  logic        r_fetch_err;
  logic [31:0] r_fetch_cnt;

  logic [31:0] w_npc;
  logic [31:0] w_f_pc4;
  logic [31:0] w_d_pc4;
  logic [31:0] w_br_off;
  logic        w_in_range;
  logic [31:0] w_fetch_word;
  logic        w_flush;

`ifdef IF_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_f_pc4  = r_f_pc + 32'd4;
  assign w_d_pc4  = r_d_pc + 32'd4;
  assign w_br_off = {{14{d_imm16[15]}}, d_imm16, 2'b00};

  assign w_in_range = ({1'b0, r_f_pc} >= {1'b0, IM_BASE}) &&
                      ({1'b0, r_f_pc} <  IM_LIMIT) &&
                      (r_f_pc[1:0] == 2'b00);
  assign w_fetch_word = w_in_range ? im_instr : 32'h0000_0000;

  // Redirects use D_pc because the branch/jump sits in D while its delay slot is fetched
  always_comb begin
    w_npc = w_f_pc4;
    case (npc_sel)
      SEL_SEQ:    w_npc = w_f_pc4;
      SEL_BRANCH: w_npc = branch_taken ? (w_d_pc4 + w_br_off) : w_f_pc4;
      SEL_JUMP:   w_npc = {w_d_pc4[31:28], d_index26, 2'b00};
      SEL_JR:     w_npc = jr_target;
      default:    w_npc = w_f_pc4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_f_pc      <= PC_RESET;
      r_d_instr   <= 32'h0000_0000;
      r_d_pc      <= 32'h0000_0000;
      r_d_pc8     <= 32'h0000_0008;
      r_d_valid   <= 1'b0;
      r_fetch_err <= 1'b0;
      r_fetch_cnt <= 32'h0000_0000;
    end else if (!stall) begin
      r_f_pc  <= w_npc;
      r_d_pc  <= r_f_pc;
      r_d_pc8 <= r_f_pc + 32'd8;
      if (w_flush) begin
        r_d_instr <= 32'h0000_0000;
        r_d_valid <= 1'b0;
      end else begin
        r_d_instr <= w_fetch_word;
        r_d_valid <= 1'b1;
        if (r_fetch_cnt != 32'hFFFF_FFFF) begin
          r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
      end
      if (!w_in_range) begin
        r_fetch_err <= 1'b1;
      end
    end
  end

  assign F_PC      = r_f_pc;
  assign D_instr   = r_d_instr;
  assign D_pc      = r_d_pc;
  assign D_pc8     = r_d_pc8;
  assign D_valid   = r_d_valid;
  assign fetch_err = r_fetch_err;
  assign fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, hand sequences, randomized run against a reference model.
module tb_if_fetch_unit;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam int          IM_DEPTH = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  npc_sel;
  logic        branch_taken;
  logic [15:0] d_imm16;
  logic [25:0] d_index26;
  logic [31:0] jr_target;
  logic [31:0] im_instr;
  logic        flush;
  logic [31:0] F_PC, D_instr, D_pc, D_pc8, fetch_cnt;
  logic        D_valid, fetch_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign im_instr = imem(F_PC);

  if_fetch_unit #(.PC_RESET(PC_RESET), .IM_BASE(IM_BASE), .IM_DEPTH(IM_DEPTH)) dut (
    .clk(clk), .reset(reset), .stall(stall), .npc_sel(npc_sel),
    .branch_taken(branch_taken), .d_imm16(d_imm16), .d_index26(d_index26),
    .jr_target(jr_target), .im_instr(im_instr),
`ifdef IF_FLUSH_EN
    .flush(flush),
`endif
    .F_PC(F_PC), .D_instr(D_instr), .D_pc(D_pc), .D_pc8(D_pc8),
    .D_valid(D_valid), .fetch_err(fetch_err), .fetch_cnt(fetch_cnt));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic [1:0] sel, input logic bt,
                       input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] jr);
    stall = s; npc_sel = sel; branch_taken = bt;
    d_imm16 = imm; d_index26 = idx; jr_target = jr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Reference model: architectural state of the fetch stage
  logic [31:0] m_fpc, m_dinstr, m_dpc, m_dpc8, m_cnt;
  logic        m_valid, m_err;

  task automatic model_step(input logic rst, input logic fl);
    logic [31:0] npc;
    logic        inr;
    longint      lim;
    if (rst) begin
      m_fpc = PC_RESET; m_dinstr = 0; m_dpc = 0; m_dpc8 = 8;
      m_valid = 0; m_err = 0; m_cnt = 0;
    end else if (!stall) begin
      lim = longint'(IM_BASE) + 4 * longint'(IM_DEPTH);
      inr = (longint'(m_fpc) >= longint'(IM_BASE)) && (longint'(m_fpc) < lim) && (m_fpc % 4 == 0);
      if (npc_sel == 2'd1 && branch_taken)
        npc = m_dpc + 4 + 32'(signed'(d_imm16)) * 4;
      else if (npc_sel == 2'd2)
        npc = ((m_dpc + 4) & 32'hF000_0000) | (32'(d_index26) * 4);
      else if (npc_sel == 2'd3)
        npc = jr_target;
      else
        npc = m_fpc + 4;
      m_dpc  = m_fpc;
      m_dpc8 = m_fpc + 8;
      if (fl) begin
        m_dinstr = 0; m_valid = 0;
      end else begin
        m_dinstr = inr ? imem(m_fpc) : 32'h0;
        m_valid = 1;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end
      if (!inr) m_err = 1;
      m_fpc = npc;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".F_PC"},      F_PC,      m_fpc);
    chk({tag, ".D_instr"},   D_instr,   m_dinstr);
    chk({tag, ".D_pc"},      D_pc,      m_dpc);
    chk({tag, ".D_pc8"},     D_pc8,     m_dpc8);
    chk({tag, ".D_valid"},   32'(D_valid),   32'(m_valid));
    chk({tag, ".fetch_err"}, 32'(fetch_err), 32'(m_err));
    chk({tag, ".fetch_cnt"}, fetch_cnt, m_cnt);
  endtask

  typedef struct {
    logic        s;
    logic [1:0]  sel;
    logic        bt;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] jr;
    logic [31:0] fpc;
    logic [31:0] dpc;
    logic [31:0] cnt;
    logic        nop;
    logic        err;
  } vec_t;

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{1'b0, 2'd0, 1'b0, 16'h0000, 26'h0, 32'h0, 32'h3004, 32'h3000, 32'd1,  1'b0, 1'b0};
    tbl[1]  = '{1'b0, 2'd0, 1'b0, 16'h0000, 26'h0, 32'h0, 32'h3008, 32'h3004, 32'd2,  1'b0, 1'b0};
    tbl[2]  = '{1'b0, 2'd0, 1'b0, 16'h0000, 26'h0, 32'h0, 32'h300C, 32'h3008, 32'd3,  1'b0, 1'b0};
    tbl[3]  = '{1'b0, 2'd1, 1'b1, 16'hFFFE, 26'h0, 32'h0, 32'h3004, 32'h300C, 32'd4,  1'b0, 1'b0};
    tbl[4]  = '{1'b0, 2'd0, 1'b0, 16'h0000, 26'h0, 32'h0, 32'h3008, 32'h3004, 32'd5,  1'b0, 1'b0};
    tbl[5]  = '{1'b0, 2'd0, 1'b0, 16'h0000, 26'h0, 32'h0, 32'h300C, 32'h3008, 32'd6,  1'b0, 1'b0};
    tbl[6]  = '{1'b0, 2'd1, 1'b0, 16'hFFFE, 26'h0, 32'h0, 32'h3010, 32'h300C, 32'd7,  1'b0, 1'b0};
    tbl[7]  = '{1'b0, 2'd3, 1'b0, 16'h0000, 26'h0, 32'h3000, 32'h3000, 32'h3010, 32'd8, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 2'd0, 1'b0, 16'h0000, 26'h0, 32'h0, 32'h3004, 32'h3000, 32'd9,  1'b0, 1'b0};
    tbl[9]  = '{1'b0, 2'd2, 1'b0, 16'h0000, 26'h0000C10, 32'h0, 32'h3040, 32'h3004, 32'd10, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 2'd3, 1'b0, 16'h0000, 26'h0, 32'h3100, 32'h3040, 32'h3004, 32'd10, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 2'd3, 1'b0, 16'h0000, 26'h0, 32'h3100, 32'h3040, 32'h3004, 32'd10, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 2'd3, 1'b0, 16'h0000, 26'h0, 32'h3100, 32'h3100, 32'h3040, 32'd11, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 2'd3, 1'b0, 16'h0000, 26'h0, 32'h0010, 32'h0010, 32'h3100, 32'd12, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 2'd0, 1'b0, 16'h0000, 26'h0, 32'h0, 32'h0014, 32'h0010, 32'd13, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 2'd0, 1'b0, 16'h0000, 26'h0, 32'h0, 32'h0018, 32'h0014, 32'd14, 1'b1, 1'b1};

    flush = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
    do_reset();

    chk("rst.F_PC", F_PC, 32'h3000);
    chk("rst.D_instr", D_instr, 32'h0);
    chk("rst.D_pc", D_pc, 32'h0);
    chk("rst.D_pc8", D_pc8, 32'h8);
    chk("rst.D_valid", 32'(D_valid), 32'h0);
    chk("rst.fetch_err", 32'(fetch_err), 32'h0);
    chk("rst.fetch_cnt", fetch_cnt, 32'h0);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].s, tbl[i].sel, tbl[i].bt, tbl[i].imm, tbl[i].idx, tbl[i].jr);
      tick();
      chk($sformatf("vec%0d.F_PC", i), F_PC, tbl[i].fpc);
      chk($sformatf("vec%0d.D_pc", i), D_pc, tbl[i].dpc);
      chk($sformatf("vec%0d.D_pc8", i), D_pc8, tbl[i].dpc + 32'd8);
      chk($sformatf("vec%0d.fetch_cnt", i), fetch_cnt, tbl[i].cnt);
      chk($sformatf("vec%0d.D_instr", i), D_instr, tbl[i].nop ? 32'h0 : imem(tbl[i].dpc));
      chk($sformatf("vec%0d.fetch_err", i), 32'(fetch_err), 32'(tbl[i].err));
      chk($sformatf("vec%0d.D_valid", i), 32'(D_valid), 32'h1);
    end

    // reset overrides a simultaneous stall and redirect, and clears the sticky error
    drive(1'b1, 2'd3, 1'b0, 16'h0, 26'h0, 32'h0000_5000);
    do_reset();
    chk("rst2.F_PC", F_PC, 32'h3000);
    chk("rst2.fetch_err", 32'(fetch_err), 32'h0);
    chk("rst2.fetch_cnt", fetch_cnt, 32'h0);
    chk("rst2.D_valid", 32'(D_valid), 32'h0);

    // misaligned fetch inside the window is also an error
    drive(1'b0, 2'd3, 1'b0, 16'h0, 26'h0, 32'h0000_3002);
    tick();
    drive(1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
    tick();
    chk("misalign.D_instr", D_instr, 32'h0);
    chk("misalign.fetch_err", 32'(fetch_err), 32'h1);

    // last word in range vs first word past the end
    drive(1'b0, 2'd3, 1'b0, 16'h0, 26'h0, 32'h0000_6FFC);
    do_reset();
    tick();
    drive(1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
    tick();
    chk("top.D_instr", D_instr, imem(32'h0000_6FFC));
    chk("top.fetch_err", 32'(fetch_err), 32'h0);
    tick();
    chk("end.D_instr", D_instr, 32'h0);
    chk("end.fetch_err", 32'(fetch_err), 32'h1);

`ifdef IF_FLUSH_EN
    drive(1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
    do_reset();
    tick();
    tick();
    chk("fl.pre.D_pc", D_pc, 32'h3004);
    flush = 1'b1;
    tick();
    chk("fl.D_instr", D_instr, 32'h0);
    chk("fl.D_valid", 32'(D_valid), 32'h0);
    chk("fl.D_pc", D_pc, 32'h3008);
    chk("fl.D_pc8", D_pc8, 32'h3010);
    chk("fl.fetch_cnt", fetch_cnt, 32'd2);
    chk("fl.F_PC", F_PC, 32'h300C);
    stall = 1'b1;
    tick();
    chk("flst.F_PC", F_PC, 32'h300C);
    chk("flst.D_pc", D_pc, 32'h3008);
    chk("flst.fetch_cnt", fetch_cnt, 32'd2);
    flush = 1'b0;
    stall = 1'b0;
`endif

    // randomized run against the reference model
    drive(1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
    do_reset();
    model_step(1'b1, 1'b0);
    for (int n = 0; n < 600; n++) begin
      logic r;
      logic fl;
      r  = ($urandom_range(0, 49) == 0);
      fl = 1'b0;
      stall        = ($urandom_range(0, 3) == 0);
      npc_sel      = 2'($urandom_range(0, 3));
      branch_taken = 1'($urandom);
      d_imm16      = 16'($urandom_range(0, 63)) - 16'd32;
      d_index26    = 26'($urandom_range(32'h0C00, 32'h1C10));
      jr_target    = ($urandom_range(0, 9) == 0) ? $urandom : (32'h3000 + 32'($urandom_range(0, 32'h0FFF)) * 4);
`ifdef IF_FLUSH_EN
      fl    = ($urandom_range(0, 7) == 0);
      flush = fl;
`endif
      reset = r;
      model_step(r, fl);
      tick();
      reset = 1'b0;
      check_model($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
